// File: rtl/whirlpool_wcipher_iter.sv
// whirlpool_wcipher_iter: iterative Whirlpool W-cipher / Miyaguchi-Preneel compression, UNROLL rounds per clock.
// State bytes are packed MSB-first: byte b = bits [8b:8b+7], row b/8, column b%8.
module whirlpool_wcipher_iter #(
  parameter int NUM_ROUNDS = 10,
  parameter int UNROLL     = 1,
  parameter int MIYAGUCHI  = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  output logic         i_ready,
  input  logic [0:511] i_data,
  input  logic [0:511] i_key,
  output logic         o_valid,
  input  logic         o_ready,
  output logic [0:511] o_data,
  output logic         o_busy
);
  localparam int RW = $clog2(NUM_ROUNDS + 2) < 4 ? 4 : $clog2(NUM_ROUNDS + 2);
  localparam logic [RW-1:0] LAST = RW'(NUM_ROUNDS - UNROLL + 1);
  // S-box built from the E, E^-1 and R mini-boxes of the Whirlpool construction
  localparam logic [63:0] E_T  = 64'h1B9CD6F3E874A250;
  localparam logic [63:0] EI_T = 64'hF0D7BE5A92C13486;
  localparam logic [63:0] R_T  = 64'h7CBDE49F638A2510;
  localparam logic [31:0] CIRC = 32'h11418529;

  if (NUM_ROUNDS < 1 || NUM_ROUNDS % UNROLL != 0) begin : g_bad
    $error("NUM_ROUNDS must be >=1 and a multiple of UNROLL");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} st_t;

  st_t           st_q, st_d;
  logic [0:511]  s_q, s_d, k_q, k_d, p_q, p_d, h_q, h_d, o_q, o_d, kn, sn;
  logic [RW-1:0] r_q, r_d;
  logic          ov_q, ov_d;

  function automatic logic [3:0] nib(input logic [63:0] t, input logic [3:0] i);
    return t[{~i, 2'b00} +: 4];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [3:0] a, b, t;
    a = nib(E_T, x[7:4]);
    b = nib(EI_T, x[3:0]);
    t = nib(R_T, a ^ b);
    return {nib(E_T, a ^ t), nib(EI_T, b ^ t)};
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1d : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xt(x);
    x4 = xt(x2);
    x8 = xt(x4);
    return ({8{c[0]}} & x) ^ ({8{c[1]}} & x2) ^ ({8{c[2]}} & x4) ^ ({8{c[3]}} & x8);
  endfunction

  // Gamma and Pi fused (Pi only moves bytes), then Theta row-times-circulant
  function automatic logic [0:511] rnd(input logic [0:511] a);
    logic [7:0]   g [8][8];
    logic [7:0]   acc;
    logic [0:511] b;
    b = '0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        g[i][j] = sbox(a[8 * (8 * ((i - j + 8) % 8) + j) +: 8]);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        acc = '0;
        for (int k = 0; k < 8; k++)
          acc = acc ^ gmul(g[i][k], CIRC[4 * (7 - (j - k + 8) % 8) +: 4]);
        b[8 * (8 * i + j) +: 8] = acc;
      end
    return b;
  endfunction

  function automatic logic [0:511] rc(input logic [RW-1:0] r);
    logic [0:511] c;
    c = '0;
    for (int j = 0; j < 8; j++)
      c[8 * j +: 8] = sbox(8'(8 * (int'(r) - 1) + j));
    return c;
  endfunction

  function automatic logic [1023:0] rounds(input logic [0:511] k0, input logic [0:511] s0,
                                           input logic [RW-1:0] r);
    logic [0:511] k, s;
    k = k0;
    s = s0;
    for (int u = 0; u < UNROLL; u++) begin
      k = rnd(k) ^ rc(r + RW'(u));
      s = rnd(s) ^ k;
    end
    return {k, s};
  endfunction

  always_comb begin
    {kn, sn} = rounds(k_q, s_q, r_q);
    st_d = st_q;
    s_d  = s_q;
    k_d  = k_q;
    p_d  = p_q;
    h_d  = h_q;
    r_d  = r_q;
    o_d  = o_q;
    ov_d = ov_q;
    if (st_q == IDLE && i_valid) begin
      k_d  = i_key;
      s_d  = i_data ^ i_key;
      p_d  = i_data;
      h_d  = i_key;
      r_d  = RW'(1);
      st_d = RUN;
    end else if (st_q == RUN) begin
      k_d = kn;
      s_d = sn;
      r_d = r_q + RW'(UNROLL);
      if (r_q == LAST) begin
        o_d  = MIYAGUCHI != 0 ? sn ^ p_q ^ h_q : sn;
        ov_d = 1'b1;
        st_d = DONE;
      end
    end else if (st_q == DONE && o_ready) begin
      ov_d = 1'b0;
      st_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= IDLE;
      s_q  <= '0;
      k_q  <= '0;
      p_q  <= '0;
      h_q  <= '0;
      r_q  <= '0;
      o_q  <= '0;
      ov_q <= 1'b0;
    end else begin
      st_q <= st_d;
      s_q  <= s_d;
      k_q  <= k_d;
      p_q  <= p_d;
      h_q  <= h_d;
      r_q  <= r_d;
      o_q  <= o_d;
      ov_q <= ov_d;
    end
  end

  assign i_ready = st_q == IDLE;
  assign o_busy  = st_q == RUN;
  assign o_valid = ov_q;
  assign o_data  = o_q;
endmodule

// File: tb/tb_whirlpool_wcipher_iter.sv
// tb_whirlpool_wcipher_iter: directed checks of the W-cipher engine against published Whirlpool digests.
module tb_whirlpool_wcipher_iter;
  localparam logic [511:0] EMPTY_BLK = {8'h80, 504'h0};
  localparam logic [511:0] ABC_BLK   = {32'h61626380, 472'h0, 8'h18};
  localparam logic [511:0] DIG_E     = 512'h19FA61D75522A4669B44E39C1D2E1726C530232130D407F89AFEE0964997F7A73E83BE698B288FEBCF88E3E03C4F0757EA8964E59B63D93708B138CC42A66EB3;
  localparam logic [511:0] DIG_ABC   = 512'h4E2448A4C6F486BB16B6562C73B4020BF3043E3A731BCE721AE1B303D97E6D4C7181EEBDB6C57E277D0E34957114CBD6C797FC9D95D8B582D225292076D4EEF5;

  typedef struct {
    logic [511:0] data;
    logic [511:0] key;
    logic [511:0] exp;
  } vec_t;

  logic         clk = 1'b0, rst_n = 1'b0, i_valid = 1'b0, o_ready = 1'b0;
  logic [511:0] i_data = '0, i_key = '0;
  logic         i_ready, o_valid, o_busy;
  logic [511:0] o_data;
  logic [3:1]   x_ir, x_ov, x_bz;
  logic [511:0] x_od [1:3];
  int           errs = 0, checks = 0, cyc_n = 0;
  vec_t         tv [2];

  whirlpool_wcipher_iter u_d (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data), .i_key(i_key),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_busy(o_busy));
  whirlpool_wcipher_iter #(.MIYAGUCHI(0)) u_raw (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(x_ir[1]), .i_data(i_data), .i_key(i_key),
    .o_valid(x_ov[1]), .o_ready(o_ready), .o_data(x_od[1]), .o_busy(x_bz[1]));
  whirlpool_wcipher_iter #(.UNROLL(2)) u_u2 (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(x_ir[2]), .i_data(i_data), .i_key(i_key),
    .o_valid(x_ov[2]), .o_ready(o_ready), .o_data(x_od[2]), .o_busy(x_bz[2]));
  whirlpool_wcipher_iter #(.UNROLL(5)) u_u5 (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(x_ir[3]), .i_data(i_data), .i_key(i_key),
    .o_valid(x_ov[3]), .o_ready(o_ready), .o_data(x_od[3]), .o_busy(x_bz[3]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chkn(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] x;
    for (int i = 0; i < 16; i++) x[32 * i +: 32] = $urandom;
    return x;
  endfunction

  initial begin
    int lat [4];
    int acc [2];
    int t, spur;
    tv[0] = '{EMPTY_BLK, 512'h0, DIG_E};
    tv[1] = '{ABC_BLK, 512'h0, DIG_ABC};
    repeat (2) step;
    rst_n = 1'b1;
    step;
    chkn("rst_i_ready", int'(i_ready), 1);
    chkn("rst_o_valid", int'(o_valid), 0);
    chkn("rst_o_busy", int'(o_busy), 0);
    chk("rst_o_data", o_data, '0);
    // empty-string job on all four variants, inputs scrambled after accept
    i_data  = EMPTY_BLK;
    i_key   = '0;
    i_valid = 1'b1;
    step;
    chkn("run_busy_ready", int'({o_busy, i_ready}), 2);
    lat = '{default: 0};
    for (int c = 1; c <= 12; c++) begin
      i_valid = 1'($urandom);
      i_data  = rnd512();
      i_key   = rnd512();
      step;
      if (o_valid && lat[0] == 0) lat[0] = c;
      for (int m = 1; m <= 3; m++) if (x_ov[m] && lat[m] == 0) lat[m] = c;
    end
    chkn("lat_default", lat[0], 10);
    chkn("lat_raw", lat[1], 10);
    chkn("lat_unroll2", lat[2], 5);
    chkn("lat_unroll5", lat[3], 2);
    chk("dig_default", o_data, DIG_E);
    chk("dig_raw_mp", x_od[1] ^ EMPTY_BLK, DIG_E);
    chk("dig_unroll2", x_od[2], DIG_E);
    chk("dig_unroll5", x_od[3], DIG_E);
    for (int c = 0; c < 7; c++) begin
      step;
      chkn("bp_hold_flags", int'({o_valid, i_ready, o_busy}), 4);
      chk("bp_hold_data", o_data, DIG_E);
    end
    i_valid = 1'b0;
    o_ready = 1'b1;
    step;
    chkn("bp_release", int'({o_valid, i_ready}), 1);
    // o_ready pulses in IDLE and RUN, random inputs during RUN
    step;
    o_ready = 1'b0;
    step;
    o_ready = 1'b1;
    step;
    chkn("idle_ordy", int'({o_valid, i_ready}), 1);
    i_data  = EMPTY_BLK;
    i_key   = '0;
    i_valid = 1'b1;
    step;
    spur = 0;
    for (int c = 1; c <= 10; c++) begin
      i_valid = 1'($urandom);
      i_data  = rnd512();
      i_key   = rnd512();
      o_ready = 1'($urandom);
      step;
      if (c < 10 && o_valid) spur++;
    end
    o_ready = 1'b0;
    i_valid = 1'b0;
    chkn("no_spurious_valid", spur, 0);
    chkn("ign_valid", int'(o_valid), 1);
    chk("ign_data", o_data, DIG_E);
    o_ready = 1'b1;
    step;
    // back-to-back table jobs with i_valid held high
    for (int v = 0; v < 2; v++) begin
      i_data  = tv[v].data;
      i_key   = tv[v].key;
      i_valid = 1'b1;
      t = 0;
      while (!i_ready && t < 40) begin
        step;
        t++;
      end
      step;
      acc[v] = cyc_n;
      t = 0;
      while (!o_valid && t < 40) begin
        step;
        t++;
      end
      chkn("tbl_latency", cyc_n - acc[v], 10);
      chk("tbl_digest", o_data, tv[v].exp);
    end
    i_valid = 1'b0;
    chkn("b2b_interval", acc[1] - acc[0], 12);
    step;
    chkn("b2b_idle", int'({o_valid, i_ready}), 1);
    // asynchronous reset in the middle of RUN
    i_data  = EMPTY_BLK;
    i_key   = '0;
    i_valid = 1'b1;
    step;
    i_valid = 1'b0;
    repeat (3) step;
    chkn("mr_busy_before", int'(o_busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chkn("mr_flags", int'({i_ready, o_valid, o_busy}), 4);
    chk("mr_o_data", o_data, '0);
    chk("mr_u5_o_data", x_od[3], '0);
    repeat (2) step;
    rst_n = 1'b1;
    step;
    i_valid = 1'b1;
    step;
    acc[0] = cyc_n;
    i_valid = 1'b0;
    t = 0;
    while (!o_valid && t < 40) begin
      step;
      t++;
    end
    chkn("mr_latency", cyc_n - acc[0], 10);
    chk("mr_digest", o_data, DIG_E);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/whirlpool_wcipher_iter.md
Name: whirlpool_wcipher_iter

Overview:
- Iterative, parametrised W-cipher engine. It applies the full keyed round (Gamma, Pi, Theta, then Sigma key-add) to both the state path and the key-schedule path, driven by round constants, for NUM_ROUNDS rounds.
- It computes UNROLL rounds per clock.
- MIYAGUCHI=1 produces the Whirlpool compression output directly.
- It sits between the message-block buffer and the hash-chaining register in the PBKDF2-HMAC-Whirlpool pipeline, and uses valid/ready handshakes on both sides.

Parameters:
- NUM_ROUNDS, 10: number of W rounds applied. Must be >=1.
- UNROLL, 1: rounds evaluated per clock. NUM_ROUNDS % UNROLL must be 0, otherwise elaboration fails via a generate-time $error.
- MIYAGUCHI, 1: 1 gives o_data = E_K(P) ^ P ^ K (compression). 0 gives o_data = E_K(P) (raw cipher).

Ports:
- clk  input  1  single clock; all flops rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  i_data/i_key valid.
- i_ready  output  1  block can accept a new job.
- i_data  input  512  plaintext / message block, [0:511].
- i_key  input  512  cipher key / chaining value H, [0:511].
- o_valid  output  1  result valid.
- o_ready  input  1  downstream accepts the result.
- o_data  output  512  result, [0:511].
- o_busy  output  1  high in RUN.

Behaviour:

Bit and byte order:
- Bit 0 is the MSB of byte 0.
- Byte b sits at row b/8, column b%8 of the 8x8 state.

Reset (rst_n low, asynchronous):
- State returns to IDLE.
- i_ready=1 (after deassertion), o_valid=0, o_busy=0, o_data=0.
- Internal S, K, P, H and the round counter are cleared to 0.
- An in-flight job is discarded; no partial result is ever presented.

FSM states: IDLE, RUN, DONE.

IDLE:
- i_ready=1.
- A job is accepted when i_valid & i_ready at the clock edge. On accept:
  - K <= i_key
  - S <= i_data ^ i_key
  - P <= i_data
  - H <= i_key
  - r <= 1
  - go to RUN.

RUN:
- i_ready=0, o_busy=1.
- Each cycle applies UNROLL consecutive rounds, r through r+UNROLL-1. For each round:
  - K <= theta(pi(gamma(K))) ^ c_r
  - S <= theta(pi(gamma(S))) ^ K_new
- Round constant c_r:
  - Byte j of row 0 (j=0..7) = SBOX[8(r-1)+j].
  - All other bytes are 0.
  - Constants are generated combinationally from r.
  - The counter r is 4 bits plus sizing for NUM_ROUNDS.
- r <= r+UNROLL.
- When the last round has been applied (r+UNROLL-1 == NUM_ROUNDS):
  - o_data <= MIYAGUCHI ? S_new ^ P ^ H : S_new
  - o_valid <= 1
  - go to DONE.
- Latency from the accept edge to o_valid high is exactly NUM_ROUNDS/UNROLL cycles (10 with defaults).

DONE:
- o_valid=1 and o_data are held stable until o_ready is sampled high.
- On o_valid & o_ready: o_valid <= 0, go to IDLE.
- i_ready stays 0 in DONE. No pass-through accept occurs in the same cycle.
- Back-to-back throughput is therefore one job per NUM_ROUNDS/UNROLL+2 cycles.

Other rules:
- i_valid while not ready: ignored. The source must hold its data.
- o_ready high outside DONE: no effect.
- i_data/i_key changing during RUN: no effect, because inputs are latched at accept.
- Gamma, Pi and Theta are the standard Whirlpool S-box, cyclical column shift (column j shifted down by j), and MDS row multiply by circ(1,1,4,1,8,5,2,9) over GF(2^8) with polynomial 0x11D.
- All round logic is combinational between the S/K registers. There is no intra-round pipelining.

Test Plan:
- Reset, then empty-string digest (defaults): after reset i_ready=1, o_valid=0, o_data=0. Present i_key=0 and i_data=0x80 followed by 63 zero bytes (length field 0). o_valid rises exactly 10 cycles after accept, and o_data = 19FA61D75522A4669B44E39C1D2E1726C530232130D407F89AFEE0964997F7A73E83BE698B288FEBCF88E3E03C4F0757EA8964E59B63D93708B138CC42A66EB3.
- Raw cipher and unroll: with MIYAGUCHI=0, o_data ^ P ^ K equals the digest above. With UNROLL=2 and UNROLL=5 the same vector gives the same digest after 5 and 2 cycles respectively.
- Output backpressure: hold o_ready=0 for 7 cycles in DONE. o_valid and o_data stay stable and i_ready stays 0. One cycle after o_ready=1 is sampled, o_valid=0 and i_ready=1.
- Back-to-back jobs: keep i_valid high with a second block "abc" padded (i_key = digest of job 1 is not required, use H=0). The second accept happens only in IDLE. Both results match the reference model, and the interval between accepts is 12 cycles.
- Reset mid-run: assert rst_n low asynchronously at cycle 4 of RUN. All outputs go to reset values immediately. After release, a new empty-string job returns the correct digest with no stale state.
- Ignored inputs: toggle i_data/i_key randomly during RUN, and pulse o_ready in IDLE and RUN. The result is unchanged and no spurious o_valid appears.
